// File: rtl/s8sp_pkg.sv
// Shared constants for the address-register arbiter: FSM encoding,
// parameter defaults and the index-width helper used by the arbiter and picker.
package s8sp_pkg;

  localparam int N_REQ_DEF      = 3;
  localparam int ACCESS_CYC_DEF = 2;
  localparam int AR_W           = 8;
  localparam int CNT_W          = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // A single requester still needs a one-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at ptr, ptr+1, ...
// wrapping modulo N_REQ; returns a one-hot winner and its index.
module rr_pick
  import s8sp_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_req;

  // Slot gi of the rotated view is requester (ptr + gi) mod N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W:0] pos;
    always_comb begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(gi);
      if (pos >= (IDX_W+1)'(N_REQ)) begin
        pos = pos - (IDX_W+1)'(N_REQ);
      end
    end
    assign rot_idx[gi] = pos[IDX_W-1:0];
    assign rot_req[gi] = req_i[pos[IDX_W-1:0]];
  end

  always_comb begin
    winner_idx_o = '0;
    any_o        = 1'b0;
    winner_o     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner_idx_o = rot_idx[k];
        any_o        = 1'b1;
      end
    end
    if (any_o) begin
      winner_o[winner_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ar_arbiter.sv
// Round-robin arbiter owning the address register: IDLE -> LOAD -> ACCESS x ACCESS_CYC
// -> DONE, with the winner's address captured at grant time.
module ar_arbiter
  import s8sp_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ACCESS_CYC = ACCESS_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] addr_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               load_ar,
  output logic [AR_W-1:0]    data_on_ar,
  output logic               busy
);

  localparam int               IDX_W    = idx_width(N_REQ);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AR_W-1:0]  addr_q, addr_d;
  logic [N_REQ-1:0] win_q, win_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [AR_W-1:0]  addr_slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
    assign addr_slice[gi] = addr_in[8*gi +: 8];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .winner_o     (pick_oh),
    .winner_idx_o (pick_idx),
    .any_o        (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    win_d     = win_q;
    win_idx_d = win_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d     = pick_oh;
          win_idx_d = pick_idx;
          addr_d    = addr_slice[pick_idx];
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = ACC_LOAD;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // Pointer moves past the winner only once the transaction retires.
        ptr_d   = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      win_q     <= '0;
      win_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      win_q     <= win_d;
      win_idx_q <= win_idx_d;
    end
  end

  // All outputs decode from registered state, so an async reset clears them at once.
  assign busy       = (state_q != ST_IDLE);
  assign gnt        = busy ? win_q : '0;
  assign load_ar    = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE) ? win_q : '0;
  assign data_on_ar = addr_q;

endmodule

// File: tb/tb_ar_arbiter.sv
// Scoreboard bench for ar_arbiter: three instances (ACCESS_CYC = 1, 2, 15) share random
// and directed stimulus; a transaction-level model queues expected loads and completions.
module tb_ar_arbiter;

  localparam int NR = 3;
  localparam int NI = 3;

  typedef struct {
    int cyc;
    int win;
    int addr;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] addr_in;

  int checks   = 0;
  int failures = 0;
  int pend [NI];

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int ac, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s (ACCESS_CYC=%0d) t=%0t actual=%0h expected=%0h", nm, ac, $time, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int AC = (gi == 0) ? 1 : (gi == 1) ? 2 : 15;

    logic [NR-1:0] gnt;
    logic [NR-1:0] done;
    logic          load_ar;
    logic          busy;
    logic [7:0]    data_on_ar;

    exp_t load_q[$];
    exp_t done_q[$];
    int   ecnt      = 0;
    int   free_edge = 0;
    int   m_ptr     = 0;
    int   gnt_run   = 0;
    int   cur_addr  = 0;

    ar_arbiter #(
      .N_REQ      (NR),
      .ACCESS_CYC (AC)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .addr_in    (addr_in),
      .gnt        (gnt),
      .done       (done),
      .load_ar    (load_ar),
      .data_on_ar (data_on_ar),
      .busy       (busy)
    );

    // Reference: a transaction occupies AC+3 edges; grant goes to the first
    // requester at or after the pointer, and the pointer then moves past it.
    always @(posedge clk) begin
      int   w;
      exp_t e;
      ecnt++;
      if (!reset) begin
        m_ptr     = 0;
        free_edge = 0;
        load_q.delete();
        done_q.delete();
      end else if (ecnt >= free_edge && req != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        end
        e.cyc  = ecnt;
        e.win  = w;
        e.addr = int'(addr_in[8*w +: 8]);
        load_q.push_back(e);
        e.cyc = ecnt + AC + 1;
        done_q.push_back(e);
        free_edge = ecnt + AC + 3;
        m_ptr     = (w + 1) % NR;
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
        check("reset_outputs", AC, int'({gnt, done, load_ar, data_on_ar, busy}), 0);
        gnt_run = 0;
      end else begin
        check("gnt_onehot0", AC, int'($onehot0(gnt)), 1);
        check("done_onehot0", AC, int'($onehot0(done)), 1);
        check("busy_vs_gnt", AC, int'(busy), int'(gnt != '0));
        if (load_ar) begin
          check("load_expected", AC, int'(load_q.size() != 0), 1);
          if (load_q.size() != 0) begin
            e = load_q.pop_front();
            check("load_cycle", AC, ecnt, e.cyc);
            check("load_gnt", AC, int'(gnt), 1 << e.win);
            check("load_addr", AC, int'(data_on_ar), e.addr);
            cur_addr = e.addr;
          end
        end
        if (gnt != '0) begin
          gnt_run++;
          check("ar_hold", AC, int'(data_on_ar), cur_addr);
        end
        if (done != '0) begin
          check("done_expected", AC, int'(done_q.size() != 0), 1);
          if (done_q.size() != 0) begin
            e = done_q.pop_front();
            check("done_cycle", AC, ecnt, e.cyc);
            check("done_vec", AC, int'(done), 1 << e.win);
            check("done_gnt", AC, int'(gnt), 1 << e.win);
            check("done_addr", AC, int'(data_on_ar), e.addr);
            check("gnt_length", AC, gnt_run, AC + 2);
            $display("txn ACCESS_CYC=%0d requester=%0d addr=%02h load@%0d done@%0d",
                     AC, e.win, e.addr, e.cyc - AC - 1, e.cyc);
          end
          gnt_run = 0;
        end
      end
      pend[gi] = load_q.size() + done_q.size();
    end

    always @(negedge reset) begin
      #1;
      check("async_reset", AC, int'({gnt, done, load_ar, data_on_ar, busy}), 0);
    end
  end

  task automatic cyc_drive(input logic [NR-1:0] r, input logic [8*NR-1:0] a);
    @(negedge clk);
    #1;
    req     = r;
    addr_in = a;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drive('0, addr_in);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (n) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    addr_in = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // single request, address 3C on requester 0
    cyc_drive(3'b001, {8'h11, 8'h22, 8'h3C});
    idle(20);

    // contention held from reset: order 0,1,2,0,...
    @(negedge clk);
    #1;
    reset   = 1'b0;
    req     = 3'b111;
    addr_in = {8'hC2, 8'hB1, 8'hA0};
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (80) @(negedge clk);
    idle(20);

    // wrap-around: grant to 1 leaves ptr=2, then 0 must beat 1
    cyc_drive(3'b010, {8'h00, 8'h51, 8'h00});
    idle(20);
    cyc_drive(3'b011, {8'h00, 8'h61, 8'h60});
    repeat (40) @(negedge clk);
    idle(20);

    // dropped request with address churn afterwards
    cyc_drive(3'b010, {8'h00, 8'hA5, 8'h00});
    for (int i = 0; i < 20; i++) cyc_drive('0, (8*NR)'($urandom));

    // reset during ACCESS, then release with req=110
    cyc_drive(3'b001, {8'h00, 8'h00, 8'h77});
    cyc_drive('0, addr_in);
    @(negedge clk);
    #1;
    reset   = 1'b0;
    req     = 3'b110;
    addr_in = {8'h92, 8'h91, 8'h90};
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 req = '0;
    idle(20);

    // randomized traffic with occasional resets
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(2);
      cyc_drive(($urandom_range(0, 1) == 0) ? '0 : NR'($urandom), (8*NR)'($urandom));
    end
    idle(20);

    for (int i = 0; i < NI; i++) check("pending_at_end", i, pend[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
